// File: rtl/tlc_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tlc_light_monitor
// Brief    : Passive safety/sequence checker on the tlc light outputs. Latches
//            the first fault code and counts violation events.
//            Optional stall watchdog: define TLC_MON_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_light_monitor #(
    parameter int MIN_YELLOW = 5,
    parameter int TW         = 5,
    parameter int MAX_STALL  = 20,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [2:0]       light_ns,
    input  logic [2:0]       light_ew,
    input  logic [1:0]       light_ped,
    input  logic             clear,
    output logic             fault,
    output logic [3:0]       fault_code,
    output logic [CNT_W-1:0] fault_cnt
);

    // Light and ped encodings shared with tlc
    localparam logic [2:0] c_RED      = 3'b100;
    localparam logic [2:0] c_YELLOW   = 3'b010;
    localparam logic [2:0] c_GREEN    = 3'b001;
    localparam logic [1:0] c_PED_NS   = 2'b01;
    localparam logic [1:0] c_PED_EW   = 2'b10;
    localparam logic [1:0] c_PED_BOTH = 2'b11;

    localparam logic [TW-1:0]    c_TMAX    = '1;
    localparam logic [TW-1:0]    c_MIN_Y   = TW'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Both tick limits must be reachable by a saturating TW-bit counter
    if ((MIN_YELLOW > (2**TW - 1)) || (MAX_STALL > (2**TW - 1))) begin : g_param_check
        $error("tlc_light_monitor: MIN_YELLOW/MAX_STALL exceed TW counter range");
    end

    logic [2:0]    r_prev_ns;
    logic [2:0]    r_prev_ew;
    logic [TW-1:0] r_ycnt_ns;
    logic [TW-1:0] r_ycnt_ew;
    logic          r_viol_q;

    logic       w_v1, w_v2, w_v3, w_v4, w_v5, w_v6, w_v7, w_v8;
    logic [3:0] w_code;
    logic       w_viol;
    logic       w_rise;

    assign w_v1 = (light_ns != c_RED) && (light_ew != c_RED);
    assign w_v2 = !(light_ns inside {c_RED, c_YELLOW, c_GREEN}) ||
                  !(light_ew inside {c_RED, c_YELLOW, c_GREEN});
    assign w_v3 = ((r_prev_ns == c_GREEN) && (light_ns == c_RED)) ||
                  ((r_prev_ew == c_GREEN) && (light_ew == c_RED));
    assign w_v4 = ((r_prev_ns == c_RED) && (light_ns == c_YELLOW)) ||
                  ((r_prev_ew == c_RED) && (light_ew == c_YELLOW));
    assign w_v5 = ((r_prev_ns == c_YELLOW) && (light_ns == c_RED) && (r_ycnt_ns < c_MIN_Y)) ||
                  ((r_prev_ew == c_YELLOW) && (light_ew == c_RED) && (r_ycnt_ew < c_MIN_Y));
    assign w_v6 = ((light_ped == c_PED_NS) && (light_ew != c_RED)) ||
                  ((light_ped == c_PED_EW) && (light_ns != c_RED));
    assign w_v7 = (light_ped == c_PED_BOTH) && ((light_ns != c_RED) || (light_ew != c_RED));

`ifdef TLC_MON_WATCHDOG_EN
    localparam logic [TW-1:0] c_STALL_LIM = TW'(MAX_STALL);

    logic [1:0]    r_prev_ped;
    logic [TW-1:0] r_stall_cnt;
    logic          w_change;

    assign w_change = (light_ns != r_prev_ns) || (light_ew != r_prev_ew) ||
                      (light_ped != r_prev_ped);
    // Counter parks at the limit, so the stall stays one continuous event
    assign w_v8 = !w_change && (r_stall_cnt == c_STALL_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_ped  <= 2'b00;
            r_stall_cnt <= '0;
        end else begin
            r_prev_ped <= light_ped;
            if (w_change)
                r_stall_cnt <= '0;
            else if (clk_en && (r_stall_cnt != c_STALL_LIM))
                r_stall_cnt <= r_stall_cnt + TW'(1);
        end
    end
`else
    assign w_v8 = 1'b0;
`endif

    always_comb begin
        w_code = 4'd0;
        if      (w_v1) w_code = 4'd1;
        else if (w_v2) w_code = 4'd2;
        else if (w_v3) w_code = 4'd3;
        else if (w_v4) w_code = 4'd4;
        else if (w_v5) w_code = 4'd5;
        else if (w_v6) w_code = 4'd6;
        else if (w_v7) w_code = 4'd7;
        else if (w_v8) w_code = 4'd8;
    end

    assign w_viol = (w_code != 4'd0);
    assign w_rise = w_viol && !r_viol_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_ns <= c_RED;
            r_prev_ew <= c_RED;
            r_ycnt_ns <= '0;
            r_ycnt_ew <= '0;
            r_viol_q  <= 1'b0;
        end else begin
            r_prev_ns <= light_ns;
            r_prev_ew <= light_ew;
            r_viol_q  <= w_viol;
            if (light_ns == c_YELLOW) begin
                if (r_prev_ns != c_YELLOW)
                    r_ycnt_ns <= '0;
                else if (clk_en && (r_ycnt_ns != c_TMAX))
                    r_ycnt_ns <= r_ycnt_ns + TW'(1);
            end
            if (light_ew == c_YELLOW) begin
                if (r_prev_ew != c_YELLOW)
                    r_ycnt_ew <= '0;
                else if (clk_en && (r_ycnt_ew != c_TMAX))
                    r_ycnt_ew <= r_ycnt_ew + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_code <= 4'd0;
            fault_cnt  <= '0;
        end else if (clear) begin
            // A violation coincident with clear survives the clear
            fault      <= w_viol;
            fault_code <= w_code;
            fault_cnt  <= w_rise ? CNT_W'(1) : '0;
        end else begin
            if (w_viol && !fault) begin
                fault      <= 1'b1;
                fault_code <= w_code;
            end
            if (w_rise && (fault_cnt != c_CNT_MAX))
                fault_cnt <= fault_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
